// File: rtl/uart_tx_feeder.sv
// Circular byte FIFO plus present/busy handshake feeding a UART transmitter.
// Optional sticky overflow flag enabled by defining UART_TX_OVF_EN.
module uart_tx_feeder #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [7:0]                 wr_data_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       busy_o,
  input  logic                       tx_tick_i,
  input  logic                       t_done_i,
  output logic [7:0]                 t_data_o,
  output logic                       tx_en_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      t_data_q, t_data_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full;
  logic            empty;
  logic            wr_accept;
  logic            pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  // Flush takes priority over a same-cycle write, so such a write is neither stored nor counted as dropped.
  assign wr_accept = wr_en_i && !full && !flush_i;
  assign pop       = (state_q == PRESENT) && tx_tick_i;

  always_comb begin
    state_d  = state_q;
    t_data_d = t_data_q;
    tx_en_d  = tx_en_q;
    case (state_q)
      IDLE: begin
        if (!empty && !flush_i) begin
          state_d  = PRESENT;
          t_data_d = mem_q[rd_ptr_q];
          tx_en_d  = 1'b1;
        end
      end
      PRESENT: begin
        // A tick means the transmitter already took the byte, even if a flush arrives alongside it.
        if (tx_tick_i) begin
          state_d = BUSY;
          tx_en_d = 1'b0;
        end else if (flush_i) begin
          state_d = IDLE;
          tx_en_d = 1'b0;
        end
      end
      BUSY: begin
        if (t_done_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      t_data_q <= 8'h00;
      tx_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      t_data_q <= t_data_d;
      tx_en_q  <= tx_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

`ifdef UART_TX_OVF_EN
  logic wr_drop;
  logic overflow_q, overflow_d;

  assign wr_drop    = wr_en_i && full && !flush_i;
  assign overflow_d = overflow_q | wr_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign full_o   = full;
  assign empty_o  = empty;
  assign count_o  = count_q;
  assign busy_o   = (state_q != IDLE);
  assign t_data_o = t_data_q;
  assign tx_en_o  = tx_en_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder (DEPTH=8); tracks UART_TX_OVF_EN for overflow expectations.
module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
`ifdef UART_TX_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       flush_i;
  logic       full_o;
  logic       empty_o;
  logic [3:0] count_o;
  logic       overflow_o;
  logic       busy_o;
  logic       tx_tick_i;
  logic       t_done_i;
  logic [7:0] t_data_o;
  logic       tx_en_o;

  int checks = 0;
  int errors = 0;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .flush_i    (flush_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o),
    .tx_tick_i  (tx_tick_i),
    .t_done_i   (t_done_i),
    .t_data_o   (t_data_o),
    .tx_en_o    (tx_en_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic flush,
                               input logic tick, input logic done);
    wr_en_i   = wr;
    wr_data_i = data;
    flush_i   = flush;
    tx_tick_i = tick;
    t_done_i  = done;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_full"},     full_o,     0);
    checkOutput({tag, "_empty"},    empty_o,    1);
    checkOutput({tag, "_count"},    count_o,    0);
    checkOutput({tag, "_overflow"}, overflow_o, 0);
    checkOutput({tag, "_busy"},     busy_o,     0);
    checkOutput({tag, "_tx_en"},    tx_en_o,    0);
    checkOutput({tag, "_t_data"},   t_data_o,   0);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [7:0] wdata;
  int         done_in;
  int         cyc;
  logic       tick_now;
  logic       wr_now;

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    checkResetValues("reset");
    rst_i = 1'b0;

    // Single byte: present two cycles after the write, pop on tick, release on done.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_count_n1", count_o, 1);
    checkOutput("a5_txen_n1", tx_en_o, 0);
    cycle();
    checkOutput("a5_txen_n2", tx_en_o, 1);
    checkOutput("a5_data_n2", t_data_o, 8'hA5);
    checkOutput("a5_busy_n2", busy_o, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_txen_after_tick", tx_en_o, 0);
    checkOutput("a5_count_after_tick", count_o, 0);
    checkOutput("a5_busy_after_tick", busy_o, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_busy_ignores_tick", busy_o, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("a5_busy_after_done", busy_o, 0);
    checkOutput("a5_data_held", t_data_o, 8'hA5);

    // Fill to DEPTH, drop a ninth write, then drain in order.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    checkOutput("fill_full", full_o, 1);
    checkOutput("fill_count", count_o, 8);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_count", count_o, 8);
    checkOutput("drop_overflow", overflow_o, OVF);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("drain%0d_txen", k), tx_en_o, 1);
      checkOutput($sformatf("drain%0d_data", k), t_data_o, k);
      applyStimulus(k == 1, 8'hFF, 1'b0, 1'b1, 1'b0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d_txen_off", k), tx_en_o, 0);
      checkOutput($sformatf("drain%0d_count", k), count_o, 8 - k);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d_idle", k), busy_o, 0);
      cycle();
    end
    checkOutput("drain_empty", empty_o, 1);
    checkOutput("drain_txen_idle", tx_en_o, 0);
    checkOutput("drain_overflow_sticky", overflow_o, OVF);

    // Flush together with a tick while presenting: byte goes out, FIFO cleared.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ft_present_data", t_data_o, 8'h11);
    checkOutput("ft_present_count", count_o, 3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("ft_busy", busy_o, 1);
    checkOutput("ft_count", count_o, 0);
    checkOutput("ft_txen", tx_en_o, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
    checkOutput("ft_idle", busy_o, 0);
    cycle();
    cycle();
    checkOutput("ft_stay_idle", busy_o, 0);
    checkOutput("ft_txen_stays", tx_en_o, 0);

    // Flush without tick while presenting, with a colliding write that must vanish.
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("fw_present", tx_en_o, 1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("fw_idle", busy_o, 0);
    checkOutput("fw_txen", tx_en_o, 0);
    checkOutput("fw_count", count_o, 0);
    checkOutput("fw_overflow", overflow_o, OVF);
    cycle();
    cycle();
    checkOutput("fw_write_discarded", empty_o, 1);
    checkOutput("fw_no_present", tx_en_o, 0);

    // Reset while busy with bytes queued.
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'h63, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rb_busy", busy_o, 1);
    checkOutput("rb_count", count_o, 2);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    checkResetValues("rb_reset");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rb_done_ignored_busy", busy_o, 0);
    checkOutput("rb_done_ignored_count", count_o, 0);
    cycle();
    checkOutput("rb_done_ignored_txen", tx_en_o, 0);

    // Continuous writes while draining, done three cycles after each tick.
    done_in = 0;
    cyc = 0;
    wdata = 8'h80;
    while (cyc < 400 && (cyc < 20 || exp_q.size() != 0 || busy_o || done_in != 0)) begin
      wr_now   = (cyc < 20);
      tick_now = tx_en_o;
      t_done_i = (done_in == 1);
      if (done_in > 0) done_in--;
      if (tick_now) begin
        exp_byte = exp_q.pop_front();
        checkOutput($sformatf("stream_data_c%0d", cyc), t_data_o, exp_byte);
        done_in = 3;
      end
      if (wr_now && exp_q.size() + (tick_now ? 1 : 0) < DEPTH) exp_q.push_back(wdata);
      wr_en_i   = wr_now;
      wr_data_i = wdata;
      tx_tick_i = tick_now;
      flush_i   = 1'b0;
      cycle();
      if (wr_now) wdata++;
      checkOutput($sformatf("stream_count_c%0d", cyc), count_o, exp_q.size());
      cyc++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_finished", cyc < 400, 1);
    checkOutput("stream_empty", empty_o, 1);
    checkOutput("stream_overflow", overflow_o, OVF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
